bw_mac_accum: RTL

//  Multiply-accumulate stage built around the combinational signed 5x4 Baugh-Wooley multiplier5x4.
//  It accepts a stream of signed operand pairs under a valid/ready handshake and registers them.

---
 rtl/bw_mac_accum_if.sv | 24 ++
 rtl/bw_mac_accum.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bw_mac_accum_if.sv
// Operand-in / result-out handshake bundle for bw_mac_accum.
// The slave modport is the accumulator; the master modport is whoever feeds it and consumes its results.
interface bw_mac_accum_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       a;
    logic [3:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             sat_flag;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, sat_flag
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, sat_flag
    );
endinterface

// File: rtl/bw_mac_accum.sv
// Signed 5x4 Baugh-Wooley multiply-accumulate. It sums N_TERMS products into a saturating
// ACC_W-bit accumulator and then holds the sum on a valid/ready output until it is taken.
module bw_mac_accum #(
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    bw_mac_accum_if.slave     bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam logic [7:0]       LAST_CNT = 8'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Baugh-Wooley array: the negative-weight partial products are inverted, and their
    // correction terms fold into the constant 2^8 + 2^4 + 2^3 (mod 2^9).
    function automatic logic [8:0] multiplier5x4(input logic [4:0] ma, input logic [3:0] mb);
        logic [8:0] p;
        p = 9'h118;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                p = p + ({8'd0, ma[i] & mb[j]} << (i + j));
        for (int j = 0; j < 3; j++)
            p = p + ({8'd0, ~(ma[4] & mb[j])} << (4 + j));
        for (int i = 0; i < 4; i++)
            p = p + ({8'd0, ~(ma[i] & mb[3])} << (3 + i));
        p = p + ({8'd0, ma[4] & mb[3]} << 7);
        return p;
    endfunction

    state_t           state, next_state;
    logic             in_ready, out_valid;
    logic             accept, done_xfer;
    logic             s1_v, s2_v;
    logic [4:0]       s1_a;
    logic [3:0]       s1_b;
    logic [8:0]       prod;
    logic [ACC_W-1:0] p_ext, s2_p;
    logic [ACC_W-1:0] acc, acc_next;
    logic [ACC_W:0]   sum_wide;
    logic             ovf;
    logic [7:0]       count;
    logic             sat_q;

    assign accept    = bus.in_valid && in_ready;
    assign done_xfer = (state == DONE) && bus.out_ready;

    assign prod  = multiplier5x4(s1_a, s1_b);
    assign p_ext = {{(ACC_W-9){prod[8]}}, prod};

    // One guard bit: overflow shows up as the top two bits of the sum disagreeing.
    assign sum_wide = {acc[ACC_W-1], acc} + {s2_p[ACC_W-1], s2_p};
    assign ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    assign acc_next = !ovf ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state is defaulted first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, ACCUM: if (accept) next_state = (count == LAST_CNT) ? DRAIN : ACCUM;
            DRAIN:       if (!s1_v && !s2_v) next_state = DONE;
            DONE:        if (bus.out_ready) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
        if (clr) next_state = IDLE;
    end

    always_comb begin
        in_ready  = rst_n && ((state == IDLE) || (state == ACCUM));
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc;
    assign bus.sat_flag  = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            acc   <= '0;
            count <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            acc   <= '0;
            count <= '0;
            sat_q <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            if (done_xfer) begin
                acc   <= '0;
                count <= '0;
                sat_q <= 1'b0;
            end else begin
                if (s2_v) begin
                    acc <= acc_next;
                    if (ovf) sat_q <= 1'b1;
                end
                if (accept) count <= count + 8'd1;
            end
        end
    end

    // NOTE: operand and product registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a <= bus.a;
            s1_b <= bus.b;
        end
        if (s1_v) s2_p <= p_ext;
    end
endmodule
